// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ      = 8;
  localparam int unsigned ID_W       = 3;
  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit encoder: position of the first 1 from bit 0, 0 when input is empty.
module prio_enc8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_vec,
  output logic [ID_W-1:0]  pos,
  output logic             valid
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    pos   = '0;
    valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        pos   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with registered one-hot grant and optional hold limit.
module rr_arb8
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       preempt
);

  state_e                state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  preempt_q, preempt_d;

  logic [ID_W-1:0]  base_c;
  logic [N_REQ-1:0] rot_c;
  logic [ID_W-1:0]  enc_pos_c;
  logic             enc_valid_c;
  logic [ID_W-1:0]  winner_c;
  logic             owner_req_c;
  logic             hold_hit_c;
  logic             release_c;

  // Rotate right so that index (ptr+1) lands on bit 0; 3-bit index wraps naturally.
  always_comb begin
    logic [ID_W-1:0] idx;
    base_c = ptr_q + ID_W'(1);
    rot_c  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx      = ID_W'(i) + base_c;
      rot_c[i] = req[idx];
    end
  end

  prio_enc8 u_prio_enc8 (
    .in_vec (rot_c),
    .pos    (enc_pos_c),
    .valid  (enc_valid_c)
  );

  assign winner_c    = enc_pos_c + base_c;
  assign owner_req_c = req[gnt_id_q];
  assign hold_hit_c  = (HOLD_MAX != 0) && (cnt_q == HOLD_CNT_W'(HOLD_MAX));
  assign release_c   = done || !owner_req_c || hold_hit_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_valid_c) begin
          state_d  = BUSY;
          gnt_d    = N_REQ'(1) << winner_c;
          gnt_id_d = winner_c;
          cnt_d    = HOLD_CNT_W'(1);
        end
      end
      BUSY: begin
        if (release_c) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = gnt_id_q;
          cnt_d     = '0;
          // Only a pure hold-limit release counts as a preemption.
          preempt_d = hold_hit_c && !done && owner_req_c;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + HOLD_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= ID_W'(N_REQ - 1);
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == BUSY);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Scoreboard bench for rr_arb8: stimulus queues expected grants, a negedge monitor checks them.
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       preempt;

  rr_arb8 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  // id: expected winner; len: grant length in cycles (0 = don't care);
  // pre: preempt expected after release; gap: idle cycles before grant (-1 = don't care)
  typedef struct {
    int id;
    int len;
    bit pre;
    int gap;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   chk_rst = 1'b0;
  bit   end_req = 1'b0;
  bit   prev_busy = 1'b0;
  int   len_cnt = 0;
  int   idle_cnt = 0;
  logic [7:0] cur_gnt = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons live here.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_rst) begin
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_preempt", int'(preempt), 0);
      end
      chk("gnt_onehot0", int'($onehot0(gnt)), 1);
      if (!busy) chk("gnt_zero_when_idle", int'(gnt), 0);

      if (busy && !prev_busy) begin
        chk("grant_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{id: -1, len: 0, pre: 1'b0, gap: -1};
        if (cur.id >= 0) begin
          chk("grant_id", int'(gnt_id), cur.id);
          chk("grant_vec", int'(gnt), int'(8'(1) << cur.id));
        end
        if (cur.gap >= 0) chk("idle_gap", idle_cnt, cur.gap);
        cur_gnt = gnt;
        len_cnt = 1;
      end else if (busy) begin
        chk("gnt_stable", int'(gnt), int'(cur_gnt));
        len_cnt++;
      end

      if (!busy && prev_busy) begin
        if (cur.len > 0) chk("grant_len", len_cnt, cur.len);
        chk("preempt_on_release", int'(preempt), int'(cur.pre));
        idle_cnt = 1;
      end else begin
        chk("preempt_quiet", int'(preempt), 0);
        if (!busy) idle_cnt++;
      end
      prev_busy = busy;

      if (end_req) begin
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy) return;
    end
    $display("FAIL wait_busy: no grant within 20 cycles, busy=%0b", busy);
    $fatal(1, "grant timeout");
  endtask

  task automatic push(input int id, input int len, input bit pre, input int gap);
    exp_t e;
    e.id = id; e.len = len; e.pre = pre; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic release_done(input logic [7:0] next_req);
    done = 1'b1;
    req  = next_req;
    tick();
    done = 1'b0;
  endtask

  initial begin
    // Reset and reset-state check
    resetn = 1'b0;
    tick();
    tick();
    mon_en  = 1'b1;
    chk_rst = 1'b1;
    tick();
    chk_rst = 1'b0;
    resetn  = 1'b1;

    // First grant after reset, then ptr=0 steers 0x81 to 7; done+req drop together
    push(0, 1, 1'b0, -1);
    req = 8'h81;
    wait_busy();
    push(7, 1, 1'b0, 1);
    release_done(8'h81);
    wait_busy();
    release_done(8'h00);

    // Full load rotation 0..7,0
    for (int i = 0; i < 9; i++) push(i % 8, 1, 1'b0, (i == 0) ? -1 : 1);
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_busy();
      release_done((i == 8) ? 8'h00 : 8'hFF);
    end

    // Wrap-around from ptr=6 with req=0b101
    push(6, 1, 1'b0, -1);
    req = 8'h40;
    wait_busy();
    push(0, 1, 1'b0, 1);
    release_done(8'h05);
    wait_busy();
    push(2, 1, 1'b0, 1);
    release_done(8'h05);
    wait_busy();
    release_done(8'h00);

    // Owner 5 drops its request while others toggle
    push(5, 3, 1'b0, -1);
    req = 8'h24;
    wait_busy();
    req = 8'h2C;
    tick();
    tick();
    push(2, 1, 1'b0, 1);
    req = 8'h04;
    tick();
    wait_busy();
    release_done(8'h00);

    // Hold limit of 4 with preempt, then re-grant
    push(3, 4, 1'b1, -1);
    push(3, 1, 1'b0, 1);
    req = 8'h08;
    wait_busy();
    repeat (4) tick();
    wait_busy();
    release_done(8'h00);

    // Hold limit coinciding with done: no preempt
    push(3, 4, 1'b0, -1);
    req = 8'h08;
    wait_busy();
    repeat (3) tick();
    release_done(8'h00);

    // done while idle is ignored
    done = 1'b1;
    repeat (2) tick();
    done = 1'b0;

    // Mid-grant reset; requests during reset are held off
    push(4, 2, 1'b0, -1);
    req = 8'hFF;
    wait_busy();
    tick();
    resetn = 1'b0;
    req    = 8'h80;
    tick();
    chk_rst = 1'b1;
    tick();
    chk_rst = 1'b0;
    resetn  = 1'b1;
    push(7, 1, 1'b0, 2);
    wait_busy();
    release_done(8'h00);

    repeat (3) tick();
    end_req = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor: did not reach summary");
    $fatal(1, "monitor stalled");
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, giving the maximum number of cycles a grant is held; 0 disables the limit; legal range 0..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req, input, 8 bits: request vector; bit i high means requester i wants the shared resource.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner releases the resource; it is sampled only in BUSY.
REQ-006 The block SHALL have port gnt, output, 8 bits: registered grant, one-hot or zero.
REQ-007 The block SHALL have port gnt_id, output, 3 bits: encoded index of the granted requester; it is valid only while gnt is nonzero.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a grant is held (state BUSY).
REQ-009 The block SHALL have port preempt, output, 1 bit: a one-cycle pulse marking a grant revoked by the hold limit.

Function
REQ-010 The block SHALL implement two states, IDLE and BUSY, with the state register, gnt, gnt_id, hold counter and last-winner pointer ptr[2:0] all registered.
REQ-011 Arbitration in IDLE, when req is nonzero, SHALL pick the winner as the first set bit of req, scanning upward from index (ptr+1) mod 8 and wrapping 7->0.
REQ-012 Rotation SHALL be implemented as: rotate req right by (ptr+1) mod 8, take the lowest-set-bit index, then add (ptr+1) mod 8 to it modulo 8 (3-bit wrap-around add).
REQ-013 Grant latency SHALL be 1 cycle: req seen in IDLE at edge N gives gnt, gnt_id and busy valid after edge N+1, and the state becomes BUSY.
REQ-014 While in IDLE with req equal to 0, the block SHALL keep gnt=0, busy=0, and leave ptr unchanged.
REQ-015 In BUSY, gnt and gnt_id SHALL stay constant whatever the other req bits do.
REQ-016 The hold counter SHALL load 1 on the grant edge and increment by 1 for each cycle spent in BUSY, saturating at 255.
REQ-017 A BUSY grant SHALL be released when any of these holds at an edge: (a) done=1; (b) req[gnt_id]=0; (c) HOLD_MAX is not 0 and the counter equals HOLD_MAX.
REQ-018 On release, the next state SHALL be IDLE, gnt SHALL become 0, busy SHALL become 0, and ptr SHALL load gnt_id.
REQ-019 There SHALL be exactly one cycle with gnt=0 between consecutive grants, even under continuous requests.
REQ-020 When release cause (c) applies and neither (a) nor (b) holds at the same edge, preempt SHALL pulse for the one cycle after release; when (a) or (b) coincide with (c), preempt SHALL stay 0.
REQ-021 When done=1 arrives in IDLE, the block SHALL ignore it and SHALL NOT change state, ptr or outputs.
REQ-022 When the owner's req drops on the same edge that done rises, the block SHALL perform a single release only, and ptr SHALL be updated once.
REQ-023 gnt SHALL never have more than one bit set, and SHALL never be nonzero while busy=0.

Reset
REQ-024 On an edge with resetn=0, the block SHALL set: state IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, counter=0, and ptr=7 so that index 0 has highest priority first.
REQ-025 Reset SHALL override everything: a reset asserted mid-grant drops gnt on that edge with no preempt pulse, and requests present during reset are not granted until the first edge after resetn returns high.

Structure
REQ-026 The following SHALL live in shared package rr_arb_pkg: constant N_REQ=8, constant ID_W=3, the state enum (IDLE, BUSY), and HOLD_CNT_W=8.
REQ-027 The lowest-set-bit search SHALL be a separate combinational sub-module, prio_enc8: 8-bit input, 3-bit position, 1-bit valid, with position 0 when the input is 0.
REQ-028 rr_arb8 SHALL instantiate prio_enc8 exactly once, on the rotated request vector.

Verification
REQ-029 Scenario, first grant after reset: reset, then req=8'b1000_0001 -> gnt=8'h01 and gnt_id=0 one cycle later, with busy=1.
REQ-030 Scenario, rotation under full load: req=8'hFF held steady, done pulsed each grant -> gnt_id sequence 0,1,2,...,7,0 with one gnt=0 cycle between grants.
REQ-031 Scenario, wrap-around: ptr=6, req=8'b0000_0101 -> gnt_id=0; next arbitration with the same req -> gnt_id=2.
REQ-032 Scenario, hold limit: HOLD_MAX=4, req=8'h08 held with done=0 -> gnt=8'h08 for exactly 4 cycles, then preempt=1 for one cycle with gnt=0, then re-grant to 3.
REQ-033 Scenario, owner drops request: owner 5 drops req[5] while req[2] is high -> release, ptr=5, next grant goes to 2 after wrap; no preempt.
REQ-034 Scenario, mid-grant reset: resetn=0 during BUSY -> all outputs 0 on that edge; after reset with req=8'h80, the first grant is 7 only after index 0..6 are checked, giving gnt_id=7.
